// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: read, commit and issue bundle for reg_file_sb.
// master = decode/commit side, slave = register file.
interface reg_file_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pending;
  logic [NRD-1:0]      rd_use;
  logic                hazard;
  logic                wen;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic [AW:0]         pend_count;

  modport master (
    output rd_addr, rd_use, wen, wr_addr,
    output wr_data, iss_valid, iss_addr,
    input  rd_data, rd_pending, hazard,
    input  pend_count
  );

  modport slave (
    input  rd_addr, rd_use, wen, wr_addr,
    input  wr_data, iss_valid, iss_addr,
    output rd_data, rd_pending, hazard,
    output pend_count
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: NRD-read / 1-write register file with pending scoreboard.
// Ports: clk, arst (sync active-low), bus (reg_file_sb_if.slave).
// Macro REGFILE_BYPASS_EN: same-cycle write-through on read ports.
module reg_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic         clk,
  input  logic         arst,
  reg_file_sb_if.slave bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  logic [AW:0]      cnt_q, cnt_d;

  logic wv, iv, same, clr, set;

  logic [NRD*XLEN-1:0] rd_data_c;
  logic [NRD-1:0]      rd_pend_c;

  always_comb begin
    wv   = bus.wen && (bus.wr_addr != '0);
    iv   = bus.iss_valid && (bus.iss_addr != '0);
    same = wv && iv && (bus.wr_addr == bus.iss_addr);
    // a same-address issue wins over the commit,
    // so that bit never falls
    clr  = wv && pend_q[bus.wr_addr] && !same;
    set  = iv && !pend_q[bus.iss_addr];
  end

  always_comb begin
    pend_d = pend_q;
    if (wv) pend_d[bus.wr_addr] = 1'b0;
    if (iv) pend_d[bus.iss_addr] = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (set && !clr) begin
      if (cnt_q != (AW+1)'(NREGS-1))
        cnt_d = cnt_q + (AW+1)'(1);
    end else if (clr && !set) begin
      if (cnt_q != '0)
        cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= '0;
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wv) regs_q[bus.wr_addr] <= bus.wr_data;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            p;

    assign a = bus.rd_addr[k*AW +: AW];

    always_comb begin
      d = (a == '0) ? '0 : regs_q[a];
      p = pend_q[a];
`ifdef REGFILE_BYPASS_EN
      if (wv && (a == bus.wr_addr)) begin
        d = bus.wr_data;
        if (!same) p = 1'b0;
      end
`endif
    end

    assign rd_data_c[k*XLEN +: XLEN] = d;
    assign rd_pend_c[k] = p;
  end

  assign bus.rd_data    = rd_data_c;
  assign bus.rd_pending = rd_pend_c;
  assign bus.hazard     = |(rd_pend_c & bus.rd_use);
  assign bus.pend_count = cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed bench for reg_file_sb.
// Drives the interface master side, checks hand-computed values.
module tb_reg_file_sb;

  logic clk;
  logic arst;
  int   errs;
  int   checks;

  reg_file_sb_if #(.XLEN(32), .AW(5), .NRD(2)) bus ();

  reg_file_sb #(
    .XLEN(32), .NREGS(32), .AW(5), .NRD(2)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.wen       = 1'b0;
    bus.iss_valid = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.iss_addr  = '0;
  endtask

  task automatic rd(input logic [4:0] a0,
                    input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask

  function automatic logic [31:0] d0();
    return bus.rd_data[31:0];
  endfunction

  function automatic logic [31:0] d1();
    return bus.rd_data[63:32];
  endfunction

  initial begin
    errs   = 0;
    checks = 0;
    arst   = 1'b0;
    quiet();
    bus.rd_use = 2'b00;
    rd(5'd0, 5'd0);
    step();
    step();
    arst = 1'b1;

    chk("rst_cnt", 64'(bus.pend_count), 64'd0);
    chk("rst_haz", 64'(bus.hazard), 64'd0);

    // reset clears loaded data and pending
    bus.wen = 1'b1; bus.wr_addr = 5'd5;
    bus.wr_data = 32'hDEADBEEF;
    step();
    quiet();
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd5;
    step();
    quiet();
    rd(5'd5, 5'd0);
    chk("pre_d5", 64'(d0()), 64'hDEADBEEF);
    chk("pre_p5", 64'(bus.rd_pending[0]), 64'd1);
    chk("pre_cnt", 64'(bus.pend_count), 64'd1);
    arst = 1'b0;
    step();
    arst = 1'b1;
    chk("rst_d5", 64'(d0()), 64'd0);
    chk("rst_p5", 64'(bus.rd_pending), 64'd0);
    chk("rst_cnt2", 64'(bus.pend_count), 64'd0);

    // x0 ignores write and issue
    bus.wen = 1'b1; bus.wr_addr = 5'd0;
    bus.wr_data = 32'h12345678;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
    step();
    quiet();
    rd(5'd0, 5'd0);
    chk("x0_data", 64'(d0()), 64'd0);
    chk("x0_pend", 64'(bus.rd_pending[0]), 64'd0);
    chk("x0_cnt", 64'(bus.pend_count), 64'd0);

    // scoreboard
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd3;
    step();
    bus.iss_addr = 5'd7;
    step();
    quiet();
    chk("sb_cnt2", 64'(bus.pend_count), 64'd2);
    bus.rd_use = 2'b01;
    rd(5'd3, 5'd0);
    chk("sb_haz", 64'(bus.hazard), 64'd1);
    bus.rd_use = 2'b10;
    #1;
    chk("sb_nohaz", 64'(bus.hazard), 64'd0);
    bus.rd_use = 2'b00;
    bus.wen = 1'b1; bus.wr_addr = 5'd3;
    bus.wr_data = 32'hA5;
    step();
    quiet();
    rd(5'd3, 5'd7);
    chk("sb_cnt1", 64'(bus.pend_count), 64'd1);
    chk("sb_p3", 64'(bus.rd_pending[0]), 64'd0);
    chk("sb_d3", 64'(d0()), 64'hA5);
    chk("sb_p7", 64'(bus.rd_pending[1]), 64'd1);

    // issue+commit on pending x9
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
    step();
    quiet();
    chk("x9_cnt", 64'(bus.pend_count), 64'd2);
    bus.wen = 1'b1; bus.wr_addr = 5'd9;
    bus.wr_data = 32'h99;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
    step();
    quiet();
    rd(5'd9, 5'd0);
    chk("x9_data", 64'(d0()), 64'h99);
    chk("x9_pend", 64'(bus.rd_pending[0]), 64'd1);
    chk("x9_cnt2", 64'(bus.pend_count), 64'd2);

    // bypass on port 1, x4 pending
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
    step();
    quiet();
    chk("byp_cnt0", 64'(bus.pend_count), 64'd3);
    bus.wen = 1'b1; bus.wr_addr = 5'd4;
    bus.wr_data = 32'h55AA;
    rd(5'd0, 5'd4);
`ifdef REGFILE_BYPASS_EN
    chk("byp_data", 64'(d1()), 64'h55AA);
    chk("byp_pend", 64'(bus.rd_pending[1]), 64'd0);
`else
    chk("byp_data", 64'(d1()), 64'h0);
    chk("byp_pend", 64'(bus.rd_pending[1]), 64'd1);
`endif
    step();
    quiet();
    chk("byp_after", 64'(d1()), 64'h55AA);
    chk("byp_cnt1", 64'(bus.pend_count), 64'd2);

    // drain x7, x9 then refresh count
    bus.wen = 1'b1; bus.wr_addr = 5'd7;
    bus.wr_data = 32'h7;
    step();
    bus.wr_addr = 5'd9;
    step();
    quiet();
    chk("drain_cnt", 64'(bus.pend_count), 64'd0);

    // fill all 31
    for (int i = 1; i < 32; i++) begin
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 5'(i);
      step();
    end
    quiet();
    chk("fill_cnt", 64'(bus.pend_count), 64'd31);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd5;
    step();
    quiet();
    chk("fill_sat", 64'(bus.pend_count), 64'd31);
    bus.rd_use = 2'b11;
    rd(5'd1, 5'd31);
    chk("fill_haz", 64'(bus.hazard), 64'd1);
    chk("fill_pnd", 64'(bus.rd_pending), 64'd3);
    for (int i = 1; i < 32; i++) begin
      bus.wen     = 1'b1;
      bus.wr_addr = 5'(i);
      bus.wr_data = 32'(i * 16);
      step();
    end
    quiet();
    rd(5'd1, 5'd31);
    chk("empty_cnt", 64'(bus.pend_count), 64'd0);
    chk("empty_haz", 64'(bus.hazard), 64'd0);
    chk("empty_d31", 64'(d1()), 64'h1F0);
    chk("empty_d1", 64'(d0()), 64'h10);

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
